fb_swap_ctrl: RTL

Parametrised frame-buffer write and buffer-swap controller for the LED matrix path. Sits between the GPMC system-bus target (`sb_*`) and the matrix scanner. It decodes bus writes into pixel-RAM writes across `NUM_BUF` buffers and exposes control and status registers. It schedules tear-free display-buffer swaps, committed only at the scanner's frame boundary, in either auto mode (triggered by the last-pixel write) or manual mode.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_swap_fsm.sv | 45 ++++
 rtl/fb_swap_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer swap controller: register map,
// register bit positions, swap FSM state encoding and a constant log2 helper.
package fb_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_SEL    = 1;
  localparam int REG_STATUS = 2;
  localparam int REG_FRAMES = 3;

  localparam int CTRL_AUTO_EN_BIT = 0;
  localparam int ST_PENDING_BIT   = 4;
  localparam int ST_ERR_BIT       = 5;
  localparam int ST_TARGET_LSB    = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_swap_fsm.sv
// Tear-free swap scheduler: holds the requested target until the scanner's
// frame boundary, then commits it to the displayed buffer.
module fb_swap_fsm
  import fb_pkg::*;
#(
  parameter int BW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic [BW-1:0] req_buf_i,
  input  logic          frame_done_i,
  output logic [BW-1:0] disp_buf_o,
  output logic          pending_o,
  output logic [BW-1:0] target_o
);

  swap_state_e   state_q;
  logic [BW-1:0] disp_q;
  logic [BW-1:0] target_q;

  // A request arriving with frame_done commits straight away; latest request wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      disp_q   <= '0;
      target_q <= '0;
    end else if (req_i && frame_done_i) begin
      disp_q   <= req_buf_i;
      target_q <= req_buf_i;
      state_q  <= ST_IDLE;
    end else if (req_i) begin
      target_q <= req_buf_i;
      state_q  <= ST_PENDING;
    end else if (frame_done_i && state_q == ST_PENDING) begin
      disp_q  <= target_q;
      state_q <= ST_IDLE;
    end
  end

  assign disp_buf_o = disp_q;
  assign pending_o  = (state_q == ST_PENDING);
  assign target_o   = target_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Bus-facing frame-buffer controller: decodes pixel writes and CTRL/SEL/
// STATUS/FRAMES registers and drives the swap scheduler.
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter  int NUM_BUF     = 2,
  parameter  int PIX_PER_BUF = 1024,
  parameter  int PIX_W       = 12,
  localparam int BW          = (clog2(NUM_BUF) < 1) ? 1 : clog2(NUM_BUF),
  localparam int AW          = clog2(NUM_BUF * PIX_PER_BUF),
  localparam int REG_BASE    = NUM_BUF * PIX_PER_BUF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sb_wr,
  input  logic             sb_rd,
  input  logic [15:0]      sb_addr,
  input  logic [15:0]      sb_wr_data,
  output logic [15:0]      sb_rd_data,
  input  logic             frame_done,
  output logic             pix_wr,
  output logic [AW-1:0]    pix_wr_addr,
  output logic [PIX_W-1:0] pix_wr_data,
  output logic [BW-1:0]    disp_buf,
  output logic             swap_pending
);

  localparam int          PW         = clog2(PIX_PER_BUF);
  localparam logic [16:0] REG_BASE_W = 17'(REG_BASE);
  localparam logic [15:0] NUM_BUF_W  = 16'(NUM_BUF);

  logic [15:0]      rd_data_q;
  logic             pix_wr_q;
  logic [AW-1:0]    pix_addr_q;
  logic [PIX_W-1:0] pix_data_q;
  logic             auto_en_q;
  logic             wr_disp_err_q;
  logic [15:0]      frames_q;

  logic          is_pix;
  logic [16:0]   reg_off;
  logic [BW-1:0] pix_buf;
  logic          pix_wr_ev, auto_req, sel_req, req;
  logic [BW-1:0] req_buf;
  logic          ctrl_wr, err_set, err_clr;
  logic [BW-1:0] target;
  logic [15:0]   status, rd_mux;

  assign is_pix    = {1'b0, sb_addr} < REG_BASE_W;
  assign reg_off   = {1'b0, sb_addr} - REG_BASE_W;
  assign pix_buf   = sb_addr[AW-1:PW];
  assign pix_wr_ev = sb_wr && is_pix;
  assign auto_req  = pix_wr_ev && auto_en_q && (&sb_addr[PW-1:0]);
  assign sel_req   = sb_wr && !is_pix && reg_off == 17'(REG_SEL) && sb_wr_data < NUM_BUF_W;
  assign req       = auto_req || sel_req;
  assign req_buf   = auto_req ? pix_buf : sb_wr_data[BW-1:0];
  assign ctrl_wr   = sb_wr && !is_pix && reg_off == 17'(REG_CTRL);
  assign err_set   = pix_wr_ev && pix_buf == disp_buf;
  assign err_clr   = sb_wr && !is_pix && reg_off == 17'(REG_STATUS) && sb_wr_data[ST_ERR_BIT];

  fb_swap_fsm #(.BW(BW)) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .req_buf_i    (req_buf),
    .frame_done_i (frame_done),
    .disp_buf_o   (disp_buf),
    .pending_o    (swap_pending),
    .target_o     (target)
  );

  always_comb begin
    status                         = '0;
    status[BW-1:0]                 = disp_buf;
    status[ST_PENDING_BIT]         = swap_pending;
    status[ST_ERR_BIT]             = wr_disp_err_q;
    status[ST_TARGET_LSB +: BW]    = target;
  end

  // Pixel space and unmapped addresses read back as zero.
  always_comb begin
    rd_mux = '0;
    if (!is_pix) begin
      case (reg_off)
        17'(REG_CTRL):   rd_mux = {15'b0, auto_en_q};
        17'(REG_STATUS): rd_mux = status;
        17'(REG_FRAMES): rd_mux = frames_q;
        default:         rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q     <= '0;
      pix_wr_q      <= 1'b0;
      pix_addr_q    <= '0;
      pix_data_q    <= '0;
      auto_en_q     <= 1'b1;
      wr_disp_err_q <= 1'b0;
      frames_q      <= '0;
    end else begin
      pix_wr_q <= pix_wr_ev;
      if (pix_wr_ev) begin
        pix_addr_q <= sb_addr[AW-1:0];
        pix_data_q <= sb_wr_data[PIX_W-1:0];
      end
      if (ctrl_wr) auto_en_q <= sb_wr_data[CTRL_AUTO_EN_BIT];
      // Set beats a same-cycle write-1-to-clear.
      if (err_set)      wr_disp_err_q <= 1'b1;
      else if (err_clr) wr_disp_err_q <= 1'b0;
      if (frame_done) frames_q <= frames_q + 16'd1;
      if (sb_rd) rd_data_q <= rd_mux;
    end
  end

  assign sb_rd_data  = rd_data_q;
  assign pix_wr      = pix_wr_q;
  assign pix_wr_addr = pix_addr_q;
  assign pix_wr_data = pix_data_q;

endmodule
